// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences reset into the core, watches its PC for halt,
// stall or timeout, and reports a verdict with the cycle count and final PC.
module core_run_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned STALL_CYCLES = 16,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  halt_addr,
  input  logic [XLEN-1:0]  pc_in,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             stalled,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [XLEN-1:0]  last_pc
);

  localparam int unsigned RST_W   = $clog2(RST_CYCLES + 1);
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES);

  // Parameter sanity; cycle_count must be able to reach TIMEOUT without wrapping.
  if (64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_w
    $error("core_run_ctrl: TIMEOUT does not fit in CNT_W bits");
  end
  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("core_run_ctrl: RST_CYCLES must be at least 1");
  end
  if (STALL_CYCLES < 2) begin : g_bad_stall_cycles
    $error("core_run_ctrl: STALL_CYCLES must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("core_run_ctrl: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [RST_W-1:0]   rst_cnt_q,   rst_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]    prev_pc_q,   prev_pc_d;
  logic               prev_valid_q, prev_valid_d;

  logic             core_rst_d, running_d, done_d;
  logic             pass_d, stalled_d, timeout_d;
  logic [CNT_W-1:0] cycle_count_d;
  logic [XLEN-1:0]  last_pc_d;

  logic halt_hit, pc_match, stall_hit, tmo_hit, finish_hit, rst_last;

  // End-of-run checks on the current pc_in; prev_pc is ignored until it has been loaded once.
  always_comb begin
    halt_hit   = (pc_in == halt_addr);
    pc_match   = prev_valid_q && (pc_in == prev_pc_q);
    stall_hit  = pc_match && (stall_cnt_q == STALL_W'(STALL_CYCLES - 1));
    tmo_hit    = (cycle_count == CNT_W'(TIMEOUT - 1));
    finish_hit = halt_hit || stall_hit || tmo_hit;
    rst_last   = (rst_cnt_q == RST_W'(RST_CYCLES - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_RESET;
      S_RESET: if (rst_last)   state_d = S_RUN;
      S_RUN:   if (finish_hit) state_d = S_DONE;
      S_DONE:  if (start)      state_d = S_RESET;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and counters.
  always_comb begin
    core_rst_d    = (state_d != S_RUN);
    running_d     = (state_d == S_RUN);
    done_d        = (state_d == S_DONE);
    pass_d        = pass;
    stalled_d     = stalled;
    timeout_d     = timeout;
    cycle_count_d = cycle_count;
    last_pc_d     = last_pc;
    rst_cnt_d     = rst_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    prev_pc_d     = prev_pc_q;
    prev_valid_d  = prev_valid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_d        = 1'b0;
          stalled_d     = 1'b0;
          timeout_d     = 1'b0;
          cycle_count_d = '0;
          rst_cnt_d     = '0;
          stall_cnt_d   = '0;
          prev_valid_d  = 1'b0;
        end
      end
      S_RESET: begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      S_RUN: begin
        cycle_count_d = cycle_count + CNT_W'(1);
        prev_pc_d     = pc_in;
        prev_valid_d  = 1'b1;
        stall_cnt_d   = pc_match ? (stall_cnt_q + STALL_W'(1)) : '0;
        if (finish_hit) begin
          last_pc_d = pc_in;
          pass_d    = halt_hit;
          stalled_d = !halt_hit && stall_hit;
          timeout_d = !halt_hit && !stall_hit && tmo_hit;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      core_rst     <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      stalled      <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      last_pc      <= '0;
      rst_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      core_rst     <= core_rst_d;
      running      <= running_d;
      done         <= done_d;
      pass         <= pass_d;
      stalled      <= stalled_d;
      timeout      <= timeout_d;
      cycle_count  <= cycle_count_d;
      last_pc      <= last_pc_d;
      rst_cnt_q    <= rst_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed runs, a phase/history model checked every
// cycle, and literal expectations for each scenario's verdict.
module tb_core_run_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RSTC   = 4;
  localparam int unsigned STALLC = 16;
  localparam int unsigned TMO    = 50;
  localparam int unsigned CNT_W  = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [XLEN-1:0]  halt_addr = '0;
  logic [XLEN-1:0]  pc_in = '0;
  logic             core_rst, running, done, pass, stalled, timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [XLEN-1:0]  last_pc;

  core_run_ctrl #(
    .XLEN(XLEN), .RST_CYCLES(RSTC), .STALL_CYCLES(STALLC), .TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt_addr(halt_addr), .pc_in(pc_in),
    .core_rst(core_rst), .running(running), .done(done), .pass(pass),
    .stalled(stalled), .timeout(timeout), .cycle_count(cycle_count), .last_pc(last_pc)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 reset, 2 run, 3 done. The run is described by the list
  // of PCs seen so far; a stall is STALLC+1 identical PCs at the tail.
  int              m_ph = 0;
  int              m_rst_seen = 0;
  bit              m_live = 1'b0;
  bit              m_pass = 1'b0, m_stall = 1'b0, m_tmo = 1'b0;
  logic [XLEN-1:0] m_last = '0;
  logic [XLEN-1:0] hist[$];

  function automatic bit tail_stalled();
    int n = hist.size();
    if (n < int'(STALLC) + 1) return 1'b0;
    for (int i = n - int'(STALLC); i < n; i++)
      if (hist[i] != hist[i-1]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    bit r, s, h_hit, s_hit, t_hit;
    logic [XLEN-1:0] h, p;
    r = rst; s = start; h = halt_addr; p = pc_in;
    if (!r) begin
      m_live = 1'b1; m_ph = 0; m_rst_seen = 0;
      m_pass = 1'b0; m_stall = 1'b0; m_tmo = 1'b0; m_last = '0;
      hist.delete();
    end else begin
      case (m_ph)
        0, 3: if (s) begin
          m_ph = 1; m_rst_seen = 0;
          m_pass = 1'b0; m_stall = 1'b0; m_tmo = 1'b0;
          hist.delete();
        end
        1: begin
          m_rst_seen++;
          if (m_rst_seen == int'(RSTC)) m_ph = 2;
        end
        2: begin
          hist.push_back(p);
          h_hit = (p == h);
          s_hit = tail_stalled();
          t_hit = (hist.size() == int'(TMO));
          if (h_hit || s_hit || t_hit) begin
            m_ph = 3; m_last = p;
            m_pass = h_hit; m_stall = !h_hit && s_hit; m_tmo = !h_hit && !s_hit;
          end
        end
        default: ;
      endcase
    end
    #1;
    if (m_live) begin
      chk("core_rst", 64'(core_rst), 64'(m_ph != 2));
      chk("running", 64'(running), 64'(m_ph == 2));
      chk("done", 64'(done), 64'(m_ph == 3));
      chk("pass", 64'(pass), 64'(m_pass));
      chk("stalled", 64'(stalled), 64'(m_stall));
      chk("timeout", 64'(timeout), 64'(m_tmo));
      chk("cycle_count", 64'(cycle_count), 64'(hist.size()));
      chk("last_pc", 64'(last_pc), 64'(m_last));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [XLEN-1:0] pcf(input int mode, input int k);
    case (mode)
      0:       return XLEN'(4 * (k - 1));
      1:       return (k < 3) ? XLEN'(4 * (k - 1)) : XLEN'(8);
      2:       return XLEN'(32'h100 + 4 * k);
      default: return XLEN'(4 * k);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start, walk through the reset window, then drive ncyc RUN-cycle PCs.
  task automatic run_prog(input int mode, input int ncyc);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_clears_done", 64'(done), 64'd0);
    chk("start_clears_flags", 64'({pass, stalled, timeout}), 64'd0);
    chk("start_clears_count", 64'(cycle_count), 64'd0);
    for (int i = 0; i < int'(RSTC); i++) begin
      chk("rst_window_core_rst", 64'(core_rst), 64'd1);
      chk("rst_window_running", 64'(running), 64'd0);
      tick(1);
    end
    for (int k = 1; k <= ncyc; k++) begin
      pc_in = pcf(mode, k);
      start = (mode == 2 && k == 10);
      if (k == 1) begin
        chk("first_run_running", 64'(running), 64'd1);
        chk("first_run_core_rst", 64'(core_rst), 64'd0);
      end
      tick(1);
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset, then idle with no start.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("idle_core_rst", 64'(core_rst), 64'd1);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_count", 64'(cycle_count), 64'd0);

    // Halt on 0x20 at the 9th RUN cycle.
    halt_addr = 32'h20;
    run_prog(0, 12);
    chk("halt_done", 64'(done), 64'd1);
    chk("halt_pass", 64'(pass), 64'd1);
    chk("halt_other_flags", 64'({stalled, timeout}), 64'd0);
    chk("halt_count", 64'(cycle_count), 64'd9);
    chk("halt_last_pc", 64'(last_pc), 64'h20);
    chk("halt_core_rst", 64'(core_rst), 64'd1);

    // Restart from DONE: stall on 0x8.
    halt_addr = 32'hFFFF_FFF0;
    run_prog(1, 25);
    chk("stall_flag", 64'(stalled), 64'd1);
    chk("stall_pass", 64'(pass), 64'd0);
    chk("stall_count", 64'(cycle_count), 64'd19);
    chk("stall_last_pc", 64'(last_pc), 64'h8);

    // Timeout, with a start pulse mid-run that must be ignored.
    run_prog(2, 55);
    chk("tmo_flag", 64'(timeout), 64'd1);
    chk("tmo_count", 64'(cycle_count), 64'd50);
    chk("tmo_last_pc", 64'(last_pc), 64'h1C8);

    // Halt and timeout on the same cycle: halt wins.
    halt_addr = 32'hC8;
    run_prog(3, 55);
    chk("prio_pass", 64'(pass), 64'd1);
    chk("prio_other_flags", 64'({stalled, timeout}), 64'd0);
    chk("prio_count", 64'(cycle_count), 64'd50);
    chk("prio_last_pc", 64'(last_pc), 64'hC8);

    // Reset in the middle of a run, then a fresh independent run.
    halt_addr = 32'hFFFF_FFF0;
    run_prog(2, 10);
    chk("mid_running", 64'(running), 64'd1);
    rst = 1'b0;
    tick(1);
    chk("midrst_core_rst", 64'(core_rst), 64'd1);
    chk("midrst_status", 64'({running, done, pass, stalled, timeout}), 64'd0);
    chk("midrst_count", 64'(cycle_count), 64'd0);
    chk("midrst_last_pc", 64'(last_pc), 64'd0);
    rst = 1'b1;
    tick(3);
    halt_addr = 32'h20;
    run_prog(0, 12);
    chk("rerun_pass", 64'(pass), 64'd1);
    chk("rerun_count", 64'(cycle_count), 64'd9);
    chk("rerun_last_pc", 64'(last_pc), 64'h20);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
